// File: rtl/serial_negate_pkg.sv
// Shared definitions for the bit-serial negate controller: state encoding,
// default word width and a most-negative-value helper.
package serial_negate_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // True when the low `width` bits of word are 1 followed by zeros.
    function automatic logic is_min_neg(input logic [31:0] word, input int unsigned width);
        logic [31:0] mask;
        logic [31:0] msb;
        mask = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
        msb  = 32'd1 << (width - 1);
        return (word & mask) == msb;
    endfunction

endpackage

// File: rtl/serial_negate_cell.sv
// Bit-serial two's-complement cell: copies bits up to the first 1, then inverts.
module serial_negate_cell
    import serial_negate_pkg::*;
(
    input  logic t_clk,
    input  logic r,
    input  logic i,
    input  logic first,
    output logic y
);

    logic seen_q;
    logic seen_d;

    always_comb begin
        y      = i ^ (seen_q & ~first);
        seen_d = first ? i : (seen_q | i);
    end

    always_ff @(posedge t_clk) begin
        if (r) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/serial_negate_ctrl.sv
// Word-level sequencer: accepts a parallel word, streams it LSB-first through
// the serial negate cell and presents the reassembled result.
module serial_negate_ctrl
    import serial_negate_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             cell_i;
    logic             cell_first;
    logic             cell_y;

    serial_negate_cell u_cell (
        .t_clk (t_clk),
        .r     (r),
        .i     (cell_i),
        .first (cell_first),
        .y     (cell_y)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        // Outside SHIFT the cell sees i=0, first=0 so its flag holds.
        cell_i     = 1'b0;
        cell_first = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cell_i     = shift_q[0];
                cell_first = (cnt_q == '0);
                result_d   = {cell_y, result_q[WIDTH-1:1]};
                shift_d    = shift_q >> 1;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // shift_q[0] is the original MSB on the last bit.
                    overflow_d = shift_q[0] & cell_y;
                    cnt_d      = '0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge t_clk) begin
        if (r) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        out_data  = result_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Self-checking bench for serial_negate_ctrl against an arithmetic negate model.
module tb_serial_negate_ctrl;
    import serial_negate_pkg::*;

    localparam int W = 8;

    logic         t_clk = 1'b0;
    logic         r;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         overflow;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    serial_negate_ctrl #(.WIDTH(W)) dut (
        .t_clk     (t_clk),
        .r         (r),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 t_clk = ~t_clk;

    function automatic logic [W-1:0] model_neg(input logic [W-1:0] x);
        logic [W-1:0] z;
        z = '0;
        return z - x;
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x);
        return is_min_neg(32'(x), W);
    endfunction

    task automatic step();
        @(posedge t_clk);
        #1;
    endtask

    // Pure stimulus: pushes one word through and reports what was observed.
    task automatic do_word(input logic [W-1:0] d, output int lat, output logic [W-1:0] od,
                           output logic ov, output logic tmo);
        int guard;
        tmo = 1'b0;
        lat = 0;
        in_valid = 1'b1;
        in_data  = d;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!in_ready) tmo = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!out_valid) tmo = 1'b1;
        od = out_data;
        ov = overflow;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b1;
        step();
        n_cmp++;
        if ({in_ready, out_valid, out_data, overflow, busy} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b data=%h ovf=%b busy=%b want 1 0 00 0 0",
                     in_ready, out_valid, out_data, overflow, busy);
        end
        r = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic [W-1:0] vecs [5];
        int lat;
        logic [W-1:0] od;
        logic ov, tmo;
        vecs = '{8'h05, 8'h00, 8'h01, 8'hFF, 8'h80};
        foreach (vecs[k]) begin
            do_word(vecs[k], lat, od, ov, tmo);
            n_cmp++;
            if (tmo || lat != W) begin
                n_bad++;
                $display("FAIL directed_latency in=%h: got %0d edges (timeout=%b) want %0d",
                         vecs[k], lat, tmo, W);
            end
            n_cmp++;
            if (od !== model_neg(vecs[k]) || ov !== model_ovf(vecs[k])) begin
                n_bad++;
                $display("FAIL directed_result in=%h: got data=%h ovf=%b want data=%h ovf=%b",
                         vecs[k], od, ov, model_neg(vecs[k]), model_ovf(vecs[k]));
            end
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL directed_return_idle in=%h: got rdy=%b vld=%b want 1 0",
                         vecs[k], in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] d, od;
        logic ov, tmo;
        for (int k = 0; k < 20; k++) begin
            d = (k % 7 == 3) ? 8'h80 : W'($urandom);
            do_word(d, lat, od, ov, tmo);
            n_cmp++;
            if (tmo || od !== model_neg(d) || ov !== model_ovf(d)) begin
                n_bad++;
                $display("FAIL random_result in=%h: got data=%h ovf=%b tmo=%b want data=%h ovf=%b",
                         d, od, ov, tmo, model_neg(d), model_ovf(d));
            end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        logic rdy_bad, hold_bad;
        rdy_bad  = 1'b0;
        hold_bad = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        step();
        in_data  = W'($urandom);
        guard = 0;
        while (!out_valid && guard < 50) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) rdy_bad = 1'b1;
            step();
            guard++;
        end
        n_cmp++;
        if (!out_valid || rdy_bad) begin
            n_bad++;
            $display("FAIL backpressure_shift: got vld=%b rdy_glitch=%b want vld=1 rdy_glitch=0",
                     out_valid, rdy_bad);
        end
        for (int c = 0; c < 5; c++) begin
            in_data = W'($urandom);
            if (out_valid !== 1'b1 || out_data !== 8'hC4 || overflow !== 1'b0 || in_ready !== 1'b0)
                hold_bad = 1'b1;
            step();
        end
        n_cmp++;
        if (hold_bad || out_data !== 8'hC4) begin
            n_bad++;
            $display("FAIL backpressure_hold: got data=%h unstable=%b want data=c4 unstable=0",
                     out_data, hold_bad);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_release: got rdy=%b vld=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        logic [W-1:0] od;
        logic ov, tmo, spurious;
        in_valid = 1'b1;
        in_data  = 8'h2A;
        step();
        in_valid = 1'b0;
        step();
        step();
        r = 1'b1;
        step();
        r = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, out_data, overflow, busy} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL midflight_reset_state: got rdy=%b vld=%b data=%h ovf=%b busy=%b want 1 0 00 0 0",
                     in_ready, out_valid, out_data, overflow, busy);
        end
        spurious = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
            step();
        end
        out_ready = 1'b0;
        n_cmp++;
        if (spurious) begin
            n_bad++;
            $display("FAIL midflight_discard: got spurious output=%b want 0", spurious);
        end
        do_word(8'h07, lat, od, ov, tmo);
        n_cmp++;
        if (tmo || od !== 8'hF9 || ov !== 1'b0 || lat != W) begin
            n_bad++;
            $display("FAIL midflight_next: got data=%h ovf=%b lat=%0d tmo=%b want data=f9 ovf=0 lat=%0d",
                     od, ov, lat, tmo, W);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q[$];
        int acc_t[$];
        int nres;
        logic prev_vld;
        logic [W-1:0] e;
        logic accepted;
        nres = 0;
        prev_vld = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = W'($urandom);
        for (int cyc = 0; cyc < 80 && nres < 4; cyc++) begin
            accepted = 1'b0;
            if (in_ready) begin
                exp_q.push_back(in_data);
                acc_t.push_back(cyc);
                accepted = 1'b1;
            end
            if (out_valid) begin
                e = (exp_q.size() > 0) ? model_neg(exp_q.pop_front()) : '0;
                n_cmp++;
                if (out_data !== e || prev_vld) begin
                    n_bad++;
                    $display("FAIL b2b_result #%0d: got data=%h long_pulse=%b want data=%h long_pulse=0",
                             nres, out_data, prev_vld, e);
                end
                nres++;
            end
            prev_vld = out_valid;
            step();
            if (accepted) in_data = W'($urandom);
        end
        in_valid  = 1'b0;
        n_cmp++;
        if (nres != 4) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d results want 4", nres);
        end
        for (int k = 0; k + 1 < acc_t.size(); k++) begin
            n_cmp++;
            if (acc_t[k+1] - acc_t[k] != W + 2) begin
                n_bad++;
                $display("FAIL b2b_interval #%0d: got %0d cycles want %0d",
                         k, acc_t[k+1] - acc_t[k], W + 2);
            end
        end
        step();
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        r         = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_negate_ctrl.md
Name: serial_negate_ctrl

Overview:
Word-level controller for the bit-serial two's-complement (negate) datapath. It accepts a parallel WIDTH-bit word over a valid/ready handshake and streams it LSB-first through a serial negate cell, one bit per clock, asserting the cell's first-bit clear on bit 0. It reassembles the serial result into a parallel word and presents it on an output valid/ready handshake. It sits between a parallel producer and consumer and is the only sequencer of the serial cell.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit counter width (derived, not overridden).

Ports:
t_clk  input  1  clock; all state updates on rising edge.
r  input  1  reset; synchronous, active-high.
in_valid  input  1  producer has a word on in_data.
in_ready  output  1  controller can accept a word this cycle.
in_data  input  WIDTH  word to negate.
out_valid  output  1  out_data/overflow hold a completed result.
out_ready  input  1  consumer accepts the result this cycle.
out_data  output  WIDTH  two's complement of the accepted word, mod 2^WIDTH.
overflow  output  1  input was the most-negative value (1 followed by WIDTH-1 zeros); result equals input.
busy  output  1  high in SHIFT and DONE.

Behaviour:
- Reset (r=1 at an edge, in any state): state=IDLE, bit counter=0, shift/result registers=0, cell state=0. Outputs: in_ready=1, out_valid=0, out_data=0, overflow=0, busy=0. A word in flight is discarded and no result is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. If in_valid=1 at an edge, load in_data into the shift register, set counter=0, and go to SHIFT. Otherwise stay in IDLE.
- SHIFT: in_ready=0. Each cycle, drive cell input bit = shift_reg[0] and first = (counter==0).
  - Capture the cell output into result[WIDTH-1], shifting result right.
  - Shift the input register right and increment the counter.
  - At the edge where counter==WIDTH-1, go to DONE. SHIFT lasts exactly WIDTH cycles.
- Cell: registered flag seen.
  - y = i XOR (seen AND NOT first).
  - seen_next = first ? i : (seen OR i).
  - Effect: bits are copied up to and including the first 1, and inverted after it.
- overflow: registered on the last SHIFT edge as input MSB AND result MSB.
- DONE: out_valid=1; out_data and overflow are held stable. If out_ready=1 at an edge, go to IDLE and clear out_valid. in_valid is ignored.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge. in_ready returns 1 in the cycle after the output handshake. Minimum issue interval is WIDTH+2 cycles.
- If out_ready is already high when DONE is entered, the handshake completes on the first DONE edge; out_valid is high for one cycle.
- in_valid during SHIFT or DONE is not acknowledged; the producer must hold it.
- Zero input gives zero output with overflow=0, because the cell never sees a 1.

Decomposition:
- Shared package serial_negate_pkg:
  - state enum {IDLE, SHIFT, DONE} (2 bits);
  - default WIDTH constant;
  - function is_min_neg(word), used by the testbench scoreboard.
- One sub-module: serial_negate_cell (ports t_clk, r, i, first, y). Holds the seen flag; same reset rules as the controller.

Test Plan:
- WIDTH=8, in_data=0x05, out_ready=1 -> out_valid after exactly 8 edges; out_data=0xFB; overflow=0.
- in_data=0x00 -> out_data=0x00; overflow=0.
- in_data=0x01 -> 0xFF. in_data=0xFF -> 0x01. Both overflow=0.
- in_data=0x80 -> out_data=0x80; overflow=1.
- in_data=0x3C with out_ready held low 5 cycles after out_valid -> out_data=0xC4 stable throughout; in_ready=0 throughout; in_ready=1 one cycle after the handshake.
- Accept 0x2A, assert r for one edge at the 3rd SHIFT cycle, then send 0x07 -> no output for 0x2A; 0x07 yields 0xF9; all outputs read reset values the cycle after r.
